div_seq: RTL and testbench

- Multi-cycle radix-2 restoring divider with control FSM; sole provider of the DIV/DIVU result to the execute stage.
- Execute stage drives operands, signedness and start; holds them stable until ready.
- Block returns {remainder, quotient} for the HI/LO write, sized to the double-register bus.
- Sits beside execute in the pipeline, clocked with the core.

---
 rtl/div_seq_pkg.sv | 21 ++
 rtl/div_step.sv | 21 ++
 rtl/div_seq.sv | 154 +++++++++++++++
 tb/tb_div_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared encodings and widths for the sequential divider.
// Imported by div_seq and div_step.
package div_seq_pkg;

    localparam int DIV_DATA_W       = 32;
    localparam int DIV_CNT_W        = 6;
    localparam int DOUBLE_REG_BUS_W = 2 * DIV_DATA_W;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract, select, shift; purely combinational.
// Working register layout: [2W:W] partial remainder with next dividend bit, [W-1:0] remaining bits/quotient.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]   i_work,
    input  logic [DATA_W-1:0]   i_divisor,
    output logic [2*DATA_W:0]   o_work
);

    logic              w_ge;
    logic [DATA_W-1:0] w_diff;

    // On success the difference is below the divisor, so W bits are enough.
    assign w_ge   = i_work[2*DATA_W:DATA_W] >= {1'b0, i_divisor};
    assign w_diff = i_work[2*DATA_W-1:DATA_W] - i_divisor;

    assign o_work = w_ge ? {w_diff, i_work[DATA_W-1:0], 1'b1}
                         : {i_work[2*DATA_W-1:0], 1'b0};

endmodule

// File: rtl/div_seq.sv
// Radix-2 restoring divider returning {remainder, quotient}; DATA_W+1 cycles start-to-ready, result held while start_i stays high.
// DIV_SEQ_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    div_state_t            r_state;
    div_state_t            w_state_nxt;
    logic [2*DATA_W:0]     r_work;
    logic [2*DATA_W:0]     w_step;
    logic [DATA_W-1:0]     r_divisor;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_ready;
    logic [2*DATA_W-1:0]   r_result;

    logic                  w_ready_nxt;
    logic [2*DATA_W-1:0]   w_result_nxt;
    logic                  w_load;
    logic                  w_iter;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_W-1:0]     w_a_mag;
    logic [DATA_W-1:0]     w_b_mag;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;

    assign w_a_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign w_b_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign w_a_mag = w_a_neg ? -opdata1_i : opdata1_i;
    assign w_b_mag = w_b_neg ? -opdata2_i : opdata2_i;

    div_step #(.DATA_W(DATA_W)) u_step (
        .i_work    (r_work),
        .i_divisor (r_divisor),
        .o_work    (w_step)
    );

    // Sign correction is applied to the last iteration's output as it is captured.
    assign w_quot = r_neg_q ? -w_step[DATA_W-1:0] : w_step[DATA_W-1:0];
    assign w_rem  = r_neg_r ? -w_step[2*DATA_W:DATA_W+1] : w_step[2*DATA_W:DATA_W+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DivFree;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = r_result;
        w_load       = 1'b0;
        w_iter       = 1'b0;
        case (r_state)
            DivFree: begin
                w_result_nxt = '0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_nxt = DivByZero;
`ifdef DIV_SEQ_EARLY_EXIT_EN
                    end else if (w_a_mag < w_b_mag) begin
                        w_state_nxt  = DivEnd;
                        w_ready_nxt  = DivResultReady;
                        w_result_nxt = {opdata1_i, {DATA_W{1'b0}}};
`endif
                    end else begin
                        w_state_nxt = DivOn;
                        w_load      = 1'b1;
                    end
                end
            end
            DivByZero: begin
                w_result_nxt = '0;
                if (annul_i) begin
                    w_state_nxt = DivFree;
                end else begin
                    w_state_nxt = DivEnd;
                    w_ready_nxt = DivResultReady;
                end
            end
            DivOn: begin
                if (annul_i || start_i == DivStop) begin
                    w_state_nxt  = DivFree;
                    w_result_nxt = '0;
                end else begin
                    w_iter = 1'b1;
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_state_nxt  = DivEnd;
                        w_ready_nxt  = DivResultReady;
                        w_result_nxt = {w_rem, w_quot};
                    end
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    w_state_nxt  = DivFree;
                    w_result_nxt = '0;
                end else begin
                    w_ready_nxt = DivResultReady;
                end
            end
            default: begin
                w_state_nxt  = DivFree;
                w_result_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready   <= DivResultNotReady;
            r_result  <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            r_ready  <= w_ready_nxt;
            r_result <= w_result_nxt;
            if (w_load) begin
                r_work    <= {{DATA_W{1'b0}}, w_a_mag, 1'b0};
                r_divisor <= w_b_mag;
                r_cnt     <= '0;
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
            end else if (w_iter) begin
                r_work <= w_step;
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    assign ready_o  = r_ready;
    assign result_o = r_result;

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq: latency, results, hold/drop, annul, reset.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DIV_SEQ_EARLY_EXIT_EN
    localparam int SMALL_LAT = 1;
`else
    localparam int SMALL_LAT = 33;
`endif

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Start in cycle T, expect ready at T+exp_lat; then hold one cycle and drop start.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int lat;
        lat = 0;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = k;
                break;
            end
            if (k == 1) begin
                opdata1_i = ~a;
                opdata2_i = 32'h0;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, result_o, exp_res);
        @(negedge clk);
        opdata1_i    = ~a;
        opdata2_i    = 32'h0;
        signed_div_i = ~sgn;
        @(posedge clk);
        #1;
        chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
        chk({tag, "_hold_res"}, result_o, exp_res);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
        chk({tag, "_drop_res"}, result_o, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rose;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 64'(ready_o), 64'd0);
        chk("rst_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
        run_div("sneg7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 33, 64'hFFFFFFFF_FFFFFFFD);
        run_div("smin_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);
        run_div("s7_neg2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
        run_div("ubig", 1'b0, 32'hFFFFFFFF, 32'h80000001, 33, 64'h7FFFFFFE_00000001);
        run_div("divzero", 1'b0, 32'd1234, 32'd0, 2, 64'd0);

        // Annul during cycle T+10; ready must never rise for the squashed op.
        rose = 1'b0;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) rose = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("annul_rdy", 64'(ready_o), 64'd0);
        chk("annul_res", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        if (ready_o) rose = 1'b1;
        chk("annul_never_rdy", 64'(rose), 64'd0);
        run_div("after_annul", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003);

        // Reset mid-iteration.
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        chk("rst_on_rdy", 64'(ready_o), 64'd0);
        chk("rst_on_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rel_rdy", 64'(ready_o), 64'd0);
        run_div("u50_5", 1'b0, 32'd50, 32'd5, 33, 64'h00000000_0000000A);

        // Reset while a result is being presented.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (33) @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        chk("rst_end_rdy", 64'(ready_o), 64'd0);
        chk("rst_end_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("u5_9", 1'b0, 32'd5, 32'd9, SMALL_LAT, 64'h00000005_00000000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
